pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Control and sequencing unit for the 3-stage pipelined CPU (fetch/decode → execute → writeback).
- Decodes the 32-bit instruction on ibus.
- Drives one-hot register-file read selects, the immediate operand and the ALU operation.
- Carries the destination select down the pipeline so the register file is written in stage 3.
- Supports stall with bubble insertion and counts retired instructions.

Parameters:
- NREG, 32, number of architectural registers; width of every one-hot select.
- CNTW, 16, width of the retire counter.

Ports:
- clk         in   1     rising-edge clock
- reset       in   1     asynchronous, active-high reset
- ibus        in   32    instruction word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct
- stall       in   1     hold the decode stage and inject a bubble into execute
- Aselect     out  NREG  one-hot read select, A port
- Bselect     out  NREG  one-hot read select, B port
- Dselect     out  NREG  one-hot write select, writeback stage; all zeros means no write
- Imm         out  1     1 = ALU B operand comes from imm_ext, not bbus
- imm_ext     out  32    sign-extended immediate, ibus[15:0]
- S           out  3     ALU operation code
- Cin         out  1     ALU carry-in; 1 for subtract
- wb_valid    out  1     a real (non-bubble) instruction is in writeback
- retire_cnt  out  CNTW  count of instructions that have entered writeback

Behaviour:
Reset (asynchronous, takes effect immediately, including mid-operation):
- All valid bits cleared; IR cleared.
- Aselect = Bselect = 0x00000001. Dselect = 0. Imm = 0. imm_ext = 0. S = ALU_ADD. Cin = 0. wb_valid = 0. retire_cnt = 0.
- A bubble, or an invalid IR, decodes to rs = rt = 0 and no write.

Stage 1, IR register:
- At a posedge with stall = 0: IR <= ibus and ir_valid <= 1.
- At a posedge with stall = 1: IR and ir_valid hold.
- Aselect = onehot(IR.rs) and Bselect = onehot(IR.rt), both decoded combinationally from the registered IR.
- Read selects are therefore valid for the whole cycle after the posedge that captured the instruction.

Decode (combinational from IR):
- Opcode 000000 is R-format. Dest = rd. Imm = 0. Funct codes: ADD 000011, SUB 000010, XOR 000001, AND 000111, OR 000100.
- Immediate opcodes: ADDI 000011, SUBI 000010, XORI 000001, ANDI 001111, ORI 001100. Dest = rt. Imm = 1.
- imm_ext = {{16{IR[15]}}, IR[15:0]} for every immediate operation, logical ones included.
- Cin = 1 only for SUB and SUBI.
- An unlisted opcode or funct is illegal: it is treated as a bubble (no write, not counted).
- Dest register 0: the ALU result is still produced, but the write select is forced to 0 (R0 always reads zero).

Stage 2, EX register (at each posedge):
- If stall = 1 or ir_valid = 0: load a bubble.
- Otherwise load Imm, imm_ext, S, Cin, dsel = onehot(dest) and ex_valid = legal.
- Outputs are registered and valid for the whole second cycle after capture.

Stage 3, WB register (at each posedge):
- Dselect <= ex_dsel; wb_valid <= ex_valid.
- retire_cnt increments when ex_valid = 1 and wraps at 2^CNTW − 1 → 0.

Latency:
- ibus captured at posedge k.
- Read selects valid after k.
- ALU control valid after k+1.
- Dselect valid after k+2.
- Throughput is one instruction per clock when not stalled.

Stall:
- The instruction held in IR re-enters EX on the first posedge with stall = 0; it is never duplicated or lost.
- The WB stage always advances.
- Stall asserted during reset is ignored.

No forwarding or hazard detection. Software separates dependent instructions by at least 2 slots.

Decomposition:
- Package pipe_pkg holds:
  - Opcode and funct constants.
  - ALU codes ALU_XOR 3'b000, ALU_SUB 3'b010, ALU_ADD 3'b011, ALU_OR 3'b110, ALU_AND 3'b100.
  - A decoded-control struct {imm, s, cin, dest, legal}.
- One sub-module, pipe_decode: purely combinational IR → control struct.
- Pipe registers and the counter live in pipe_ctrl.

Test Plan:
- Reset asserted mid-stream with valid instructions in all stages → outputs return immediately to reset values: Aselect = 0x1, Bselect = 0x1, Dselect = 0, wb_valid = 0, retire_cnt = 0.
- ADDI R1,R0,#0000 at k → after k: Aselect = 0x1, Bselect = 0x2. After k+1: Imm = 1, imm_ext = 0, S = ADD, Cin = 0. After k+2: Dselect = 0x2, retire_cnt = 1.
- ORI R21,R1,#F98B then SUBI R31,R21,#0030 → first: imm_ext = 0xFFFFF98B, S = OR, Dselect = 0x00200000. Second: Aselect = 0x00200000, imm_ext = 0x30, S = SUB, Cin = 1, Dselect = 0x80000000.
- SUB R0,R0,R0 → S = SUB, Cin = 1. Dselect = 0 two cycles later, wb_valid = 1, counted.
- stall = 1 for 2 cycles with XOR R16,R1,R3 in IR → two bubbles reach WB (Dselect = 0, wb_valid = 0). XOR then completes once (Dselect = 0x00010000). The next ibus word is not captured until stall = 0.
- Illegal opcode 111111, followed by back-to-back legal instructions with retire_cnt preset near 0xFFFF → illegal yields no write and no count. The counter wraps 0xFFFF → 0x0000.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and decoded-control bundle for the
// three-stage pipeline controller.
package pipe_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000011;
  localparam logic [5:0] OP_SUBI = 6'b000010;
  localparam logic [5:0] OP_XORI = 6'b000001;
  localparam logic [5:0] OP_ANDI = 6'b001111;
  localparam logic [5:0] OP_ORI  = 6'b001100;

  localparam logic [5:0] FN_ADD = 6'b000011;
  localparam logic [5:0] FN_SUB = 6'b000010;
  localparam logic [5:0] FN_XOR = 6'b000001;
  localparam logic [5:0] FN_AND = 6'b000111;
  localparam logic [5:0] FN_OR  = 6'b000100;

  localparam logic [2:0] ALU_XOR = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b100;

  typedef struct packed {
    logic       imm;
    logic [2:0] s;
    logic       cin;
    logic [4:0] dest;
    logic       legal;
  } ctl_t;

endpackage

// File: rtl/pipe_decode.sv
// Combinational instruction decode: IR fields to
// ALU control, destination and legality.
module pipe_decode
  import pipe_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic [5:0] fn,
  output ctl_t       ctl
);

  always_comb begin
    ctl.imm   = 1'b0;
    ctl.s     = ALU_ADD;
    ctl.cin   = 1'b0;
    ctl.dest  = 5'd0;
    ctl.legal = 1'b0;
    if (op == OP_R) begin
      ctl.dest  = rd;
      ctl.legal = 1'b1;
      unique case (fn)
        FN_ADD: ctl.s = ALU_ADD;
        FN_SUB: begin
          ctl.s   = ALU_SUB;
          ctl.cin = 1'b1;
        end
        FN_XOR: ctl.s = ALU_XOR;
        FN_AND: ctl.s = ALU_AND;
        FN_OR:  ctl.s = ALU_OR;
        default: ctl.legal = 1'b0;
      endcase
    end else begin
      ctl.dest  = rt;
      ctl.imm   = 1'b1;
      ctl.legal = 1'b1;
      unique case (op)
        OP_ADDI: ctl.s = ALU_ADD;
        OP_SUBI: begin
          ctl.s   = ALU_SUB;
          ctl.cin = 1'b1;
        end
        OP_XORI: ctl.s = ALU_XOR;
        OP_ANDI: ctl.s = ALU_AND;
        OP_ORI:  ctl.s = ALU_OR;
        default: begin
          ctl.legal = 1'b0;
          ctl.imm   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: IR, EX and WB registers, stall
// bubbles and the retire counter.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int NREG = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     ibus,
  input  logic            stall,
  output logic [NREG-1:0] Aselect,
  output logic [NREG-1:0] Bselect,
  output logic [NREG-1:0] Dselect,
  output logic            Imm,
  output logic [31:0]     imm_ext,
  output logic [2:0]      S,
  output logic            Cin,
  output logic            wb_valid,
  output logic [CNTW-1:0] retire_cnt
);

  function automatic logic [NREG-1:0] onehot(
    input logic [4:0] idx
  );
    return NREG'(1) << idx;
  endfunction

  logic [31:0]     ir;
  logic            ir_valid;
  ctl_t            ctl;
  logic            go;
  logic [NREG-1:0] ex_dsel;
  logic            ex_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (!stall) begin
      ir       <= ibus;
      ir_valid <= 1'b1;
    end
  end

  assign Aselect = ir_valid ? onehot(ir[25:21]) : NREG'(1);
  assign Bselect = ir_valid ? onehot(ir[20:16]) : NREG'(1);

  pipe_decode u_dec (
    .op  (ir[31:26]),
    .rt  (ir[20:16]),
    .rd  (ir[15:11]),
    .fn  (ir[5:0]),
    .ctl (ctl)
  );

  // Stalls, empty IR and illegal words all enter EX as bubbles.
  assign go = !stall && ir_valid && ctl.legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Imm      <= 1'b0;
      imm_ext  <= '0;
      S        <= ALU_ADD;
      Cin      <= 1'b0;
      ex_dsel  <= '0;
      ex_valid <= 1'b0;
    end else if (!go) begin
      Imm      <= 1'b0;
      imm_ext  <= '0;
      S        <= ALU_ADD;
      Cin      <= 1'b0;
      ex_dsel  <= '0;
      ex_valid <= 1'b0;
    end else begin
      Imm      <= ctl.imm;
      imm_ext  <= {{16{ir[15]}}, ir[15:0]};
      S        <= ctl.s;
      Cin      <= ctl.cin;
      ex_dsel  <= (ctl.dest == 5'd0) ? '0
                                     : onehot(ctl.dest);
      ex_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Dselect    <= '0;
      wb_valid   <= 1'b0;
      retire_cnt <= '0;
    end else begin
      Dselect  <= ex_dsel;
      wb_valid <= ex_valid;
      if (ex_valid)
        retire_cnt <= retire_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a per-cycle instruction
// model feeds queues that a monitor drains and compares.
module tb_pipe_ctrl;

  localparam logic [2:0] A_ADD = 3'b011;
  // table order: ADD, SUB, XOR, AND, OR
  localparam bit [5:0] RFN [5] =
    '{6'h03, 6'h02, 6'h01, 6'h07, 6'h04};
  localparam bit [5:0] IOP [5] =
    '{6'h03, 6'h02, 6'h01, 6'h0F, 6'h0C};
  localparam bit [2:0] ALU [5] =
    '{3'b011, 3'b010, 3'b000, 3'b100, 3'b110};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ibus = '0;
  logic        stall = 1'b1;
  logic [31:0] Aselect, Bselect, Dselect, imm_ext;
  logic        Imm, Cin, wb_valid;
  logic [2:0]  S;
  logic [15:0] retire_cnt;

  pipe_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .ibus       (ibus),
    .stall      (stall),
    .Aselect    (Aselect),
    .Bselect    (Bselect),
    .Dselect    (Dselect),
    .Imm        (Imm),
    .imm_ext    (imm_ext),
    .S          (S),
    .Cin        (Cin),
    .wb_valid   (wb_valid),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } sel_e;
  typedef struct {
    logic        imm;
    logic [31:0] ext;
    logic [2:0]  s;
    logic        cin;
  } ex_e;
  typedef struct {
    logic [31:0] d;
    logic        v;
    logic [15:0] c;
  } wb_e;

  sel_e sel_q[$];
  ex_e  ex_q[$];
  wb_e  wb_q[$];

  int checks = 0;
  int failures = 0;
  bit mon_en = 0;

  logic [31:0] held;
  bit          held_v;
  int          cnt;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(
    input  logic [31:0] w,
    output bit          lg,
    output bit          im,
    output logic [2:0]  op,
    output bit          ci,
    output logic [4:0]  de
  );
    lg = 0; im = 0; op = A_ADD; ci = 0; de = 0;
    for (int i = 0; i < 5; i++) begin
      if (w[31:26] == 6'd0 && w[5:0] == RFN[i]) begin
        lg = 1; op = ALU[i]; ci = (i == 1);
        de = w[15:11];
      end
      if (w[31:26] != 6'd0 && w[31:26] == IOP[i]) begin
        lg = 1; im = 1; op = ALU[i]; ci = (i == 1);
        de = w[20:16];
      end
    end
  endfunction

  function automatic logic [31:0] gen(input bit ill);
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, ill ? 11 : 9);
    if (k < 5) begin
      w[31:26] = 6'd0;
      w[5:0] = RFN[k];
    end else if (k < 10) begin
      w[31:26] = IOP[k-5];
    end else if (k == 10) begin
      w[31:26] = 6'($urandom_range(16, 63));
    end else begin
      w[31:26] = 6'd0;
      w[5:0] = 6'($urandom_range(8, 63));
    end
    return w;
  endfunction

  function automatic void model_reset();
    wb_e b;
    sel_q.delete();
    ex_q.delete();
    wb_q.delete();
    held = '0;
    held_v = 0;
    cnt = 0;
    b.d = '0; b.v = 0; b.c = '0;
    wb_q.push_back(b);
  endfunction

  // one clock of stimulus plus the expected outcome of its posedge
  task automatic step(input bit st, input logic [31:0] w);
    ex_e e;
    wb_e b;
    sel_e s;
    bit lg, im, ci;
    logic [2:0] op;
    logic [4:0] de;
    @(negedge clk);
    stall = st;
    ibus = w;
    e.imm = 0; e.ext = '0; e.s = A_ADD; e.cin = 0;
    b.d = '0; b.v = 0;
    if (!st && held_v) begin
      ref_decode(held, lg, im, op, ci, de);
      if (lg) begin
        e.imm = im;
        e.ext = {{16{held[15]}}, held[15:0]};
        e.s = op;
        e.cin = ci;
        b.v = 1;
        b.d = (de == 0) ? 32'd0 : (32'd1 << de);
      end
    end
    cnt = (cnt + int'(b.v)) % 65536;
    b.c = 16'(cnt);
    if (!st) begin
      held = w;
      held_v = 1;
    end
    s.a = held_v ? (32'd1 << held[25:21]) : 32'd1;
    s.b = held_v ? (32'd1 << held[20:16]) : 32'd1;
    sel_q.push_back(s);
    ex_q.push_back(e);
    wb_q.push_back(b);
  endtask

  always @(posedge clk) begin
    sel_e s;
    ex_e  e;
    wb_e  b;
    #1;
    if (mon_en) begin
      if (sel_q.size() == 0 || ex_q.size() == 0 ||
          wb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty act=empty exp=entry");
      end else begin
        s = sel_q.pop_front();
        e = ex_q.pop_front();
        b = wb_q.pop_front();
        chk("rd_sel", {Aselect, Bselect}, {s.a, s.b});
        chk("ex_ctl", {27'd0, Imm, imm_ext, S, Cin},
            {27'd0, e.imm, e.ext, e.s, e.cin});
        chk("wb", {15'd0, Dselect, wb_valid, retire_cnt},
            {15'd0, b.d, b.v, b.c});
      end
    end
  end

  task automatic reset_check(input string tag);
    chk({tag, "_A"}, 64'(Aselect), 64'd1);
    chk({tag, "_B"}, 64'(Bselect), 64'd1);
    chk({tag, "_D"}, 64'(Dselect), 64'd0);
    chk({tag, "_Imm"}, 64'(Imm), 64'd0);
    chk({tag, "_ext"}, 64'(imm_ext), 64'd0);
    chk({tag, "_S"}, 64'(S), 64'(A_ADD));
    chk({tag, "_Cin"}, 64'(Cin), 64'd0);
    chk({tag, "_wbv"}, 64'(wb_valid), 64'd0);
    chk({tag, "_cnt"}, 64'(retire_cnt), 64'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3;
    reset = 0;
    model_reset();
    mon_en = 1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_check("rst");
    release_reset();

    step(0, {6'h03, 5'd0, 5'd1, 16'h0000});
    step(0, {6'h0C, 5'd1, 5'd21, 16'hF98B});
    step(0, {6'h02, 5'd21, 5'd31, 16'h0030});
    step(0, {6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h02});
    step(0, {6'h00, 5'd1, 5'd3, 5'd16, 5'd0, 6'h01});
    step(1, gen(1));
    step(1, gen(1));
    step(0, {6'h3F, 26'h1234567});
    step(0, gen(0));
    step(0, gen(0));

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) == 0), gen(1));

    // asynchronous reset in the middle of a clock phase
    @(posedge clk);
    #3;
    mon_en = 0;
    reset = 1;
    stall = 1;
    #1;
    reset_check("mid_rst");
    release_reset();

    step(0, gen(0));
    while (cnt != 16'hFFFC)
      step(0, gen(0));
    step(0, {6'h3F, 26'h0ABCDEF});
    for (int i = 0; i < 6; i++)
      step(0, gen(0));
    for (int i = 0; i < 3; i++)
      step(1, gen(1));

    @(posedge clk);
    #3;
    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
